// File: rtl/lcd_update_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : lcd_pkg                                                 |
// | Purpose  : Shared LCD12864 text-frame geometry, line base          |
// |            addresses and FSM state encodings.                      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package lcd_pkg;

  localparam int LCD_LINES = 4;
  localparam int LCD_COLS  = 16;
  localparam int LCD_CHARS = 64;
  localparam logic [7:0] LCD_SPACE = 8'h20;

  // DDRAM base address of each text line on the LCD12864 controller.
  localparam logic [7:0] LCD_LINE_BASE [LCD_LINES] = '{8'h80, 8'h90, 8'h88, 8'h98};

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_COPY = 2'd1,
    C_DONE = 2'd2
  } copy_state_t;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_WAIT_HI = 2'd1,
    R_WAIT_LO = 2'd2
  } refresh_state_t;

  // Controller address of the first character on a given line.
  function automatic logic [7:0] line_base_addr(input logic [1:0] line);
    return LCD_LINE_BASE[line];
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_update_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface: lcd_update_arbiter_if                                   |
// | Purpose  : Requester handshake and driver read/refresh signals of  |
// |            the LCD update arbiter.                                 |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
interface lcd_update_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_line;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        char_idx;
  logic [NREQ-1:0]   done;
  logic [3:0]        dirty;
  logic [5:0]        lcd_rd_addr;
  logic [7:0]        lcd_rd_data;
  logic              lcd_start;
  logic              lcd_busy;

  // Requesters and the LCD driver side.
  modport master (
    output req, req_line, req_char, lcd_rd_addr, lcd_busy,
    input  gnt, char_idx, done, dirty, lcd_rd_data, lcd_start
  );

  // Arbiter side.
  modport slave (
    input  req, req_line, req_char, lcd_rd_addr, lcd_busy,
    output gnt, char_idx, done, dirty, lcd_rd_data, lcd_start
  );
endinterface
`default_nettype wire

// File: rtl/lcd_update_arbiter_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rr_arbiter                                              |
// | Purpose  : Combinational round-robin pick: first active request    |
// |            at or after the pointer, one-hot plus binary index.     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_valid
);

  // Ordered search from the pointer; the first hit wins so ties cannot occur.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int w_j;
      w_j = (int'(i_ptr) + k) % NREQ;
      if (!o_valid && i_req[w_j]) begin
        o_valid    = 1'b1;
        o_gnt[w_j] = 1'b1;
        o_idx      = IW'(w_j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/lcd_update_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : lcd_update_arbiter                                      |
// | Purpose  : Round-robin line copy into a 64-byte LCD shadow buffer  |
// |            and tear-free scheduling of full-screen refreshes.      |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module lcd_update_arbiter
  import lcd_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int BUSY_TO = 1000
) (
  input  logic                 CLK,
  input  logic                 RST,
  lcd_update_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(BUSY_TO + 1);

  copy_state_t          r_cstate;
  refresh_state_t       r_rstate;
  logic [NREQ-1:0]      r_req_q;
  logic [NREQ-1:0]      r_gnt;
  logic [NREQ-1:0]      r_done;
  logic [IW-1:0]        r_gidx;
  logic [IW-1:0]        r_rr_ptr;
  logic [1:0]           r_line;
  logic [3:0]           r_char_idx;
  logic [LCD_LINES-1:0] r_dirty;
  logic [LCD_LINES-1:0] r_dirty_saved;
  logic                 r_start;
  logic [TW-1:0]        r_to_cnt;
  logic [7:0]           r_buf [LCD_CHARS];

  logic [NREQ-1:0]      w_arb_gnt;
  logic [IW-1:0]        w_arb_idx;
  logic                 w_arb_valid;
  logic                 w_launch;
  logic                 w_grant;
  logic                 w_timeout;
  logic                 w_last_char;
  logic [1:0]           w_line_sel;
  logic [7:0]           w_char;
  logic [5:0]           w_wr_addr;
  logic [IW-1:0]        w_rr_next;
  logic [LCD_LINES-1:0] w_dirty_next;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .i_req   (r_req_q),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  assign w_line_sel = bus.req_line[2*int'(w_arb_idx) +: 2];
  assign w_char     = bus.req_char[8*int'(r_gidx) +: 8];
  assign w_wr_addr  = {r_line, r_char_idx};
  assign w_rr_next  = (r_gidx == IW'(NREQ - 1)) ? '0 : r_gidx + IW'(1);

  // Launch/grant decisions; a pending refresh always wins over a new grant.
  always_comb begin
    w_launch    = (r_rstate == R_IDLE) && (r_cstate == C_IDLE) &&
                  (r_dirty != '0) && !bus.lcd_busy;
    w_grant     = (r_cstate == C_IDLE) && (r_rstate == R_IDLE) &&
                  !w_launch && w_arb_valid;
    w_timeout   = (r_rstate == R_WAIT_HI) && !bus.lcd_busy &&
                  (r_to_cnt == TW'(BUSY_TO - 1));
    w_last_char = (r_cstate == C_COPY) && (r_char_idx == 4'(LCD_COLS - 1));
    w_dirty_next = r_dirty;
    if (w_launch)    w_dirty_next = '0;
    if (w_timeout)   w_dirty_next = r_dirty | r_dirty_saved;
    if (w_last_char) w_dirty_next[r_line] = 1'b1;
  end

  // Buffer, copy FSM, refresh FSM and timeout counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cstate      <= C_IDLE;
      r_rstate      <= R_IDLE;
      r_req_q       <= '0;
      r_gnt         <= '0;
      r_done        <= '0;
      r_gidx        <= '0;
      r_rr_ptr      <= '0;
      r_line        <= '0;
      r_char_idx    <= '0;
      r_dirty       <= '1;
      r_dirty_saved <= '0;
      r_start       <= 1'b0;
      r_to_cnt      <= '0;
      for (int i = 0; i < LCD_CHARS; i++) r_buf[i] <= LCD_SPACE;
    end else begin
      r_start <= 1'b0;
      r_done  <= '0;
      r_dirty <= w_dirty_next;
      // The finishing requester still holds req until it sees done; mask it
      // so that stale level does not earn an extra copy.
      r_req_q <= bus.req & ~r_done & ~((r_cstate == C_DONE) ? r_gnt : '0);

      case (r_rstate)
        R_IDLE: begin
          if (w_launch) begin
            r_start       <= 1'b1;
            r_dirty_saved <= r_dirty;
            r_to_cnt      <= '0;
            r_rstate      <= R_WAIT_HI;
          end
        end
        R_WAIT_HI: begin
          if (bus.lcd_busy)   r_rstate <= R_WAIT_LO;
          else if (w_timeout) r_rstate <= R_IDLE;
          else                r_to_cnt <= r_to_cnt + TW'(1);
        end
        R_WAIT_LO: begin
          if (!bus.lcd_busy) r_rstate <= R_IDLE;
        end
        default: r_rstate <= R_IDLE;
      endcase

      case (r_cstate)
        C_IDLE: begin
          if (w_grant) begin
            r_gnt      <= w_arb_gnt;
            r_gidx     <= w_arb_idx;
            r_line     <= w_line_sel;
            r_char_idx <= '0;
            r_cstate   <= C_COPY;
          end
        end
        C_COPY: begin
          r_buf[w_wr_addr] <= w_char;
          r_char_idx       <= r_char_idx + 4'd1;
          if (w_last_char) r_cstate <= C_DONE;
        end
        C_DONE: begin
          r_done   <= r_gnt;
          r_gnt    <= '0;
          r_rr_ptr <= w_rr_next;
          r_cstate <= C_IDLE;
        end
        default: r_cstate <= C_IDLE;
      endcase
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.char_idx    = r_char_idx;
  assign bus.done        = r_done;
  assign bus.dirty       = r_dirty;
  assign bus.lcd_start   = r_start;
  assign bus.lcd_rd_data = r_buf[bus.lcd_rd_addr];

endmodule
`default_nettype wire
